// File: rtl/adder_sum_pipe_pkg.sv
// Shared widths, buffer state encoding and result record for the adder sum pipe.
package adder_sum_pipe_pkg;

    // Operand/sum width and pass-through tag width used by every file of the pipe.
    localparam int LEN_DATA = 32;
    localparam int LEN_TAG  = 4;

    // Buffer occupancy: the state value is the number of held results.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    // One buffered result with its tag.
    typedef struct packed {
        logic [LEN_TAG-1:0]  tag;
        logic                zero;
        logic                overflow;
        logic                carry_out;
        logic [LEN_DATA-1:0] sum;
    } result_t;

endpackage

// File: rtl/adder_sum_cell.sv
// Final stage of a prefix adder: turns group generate/propagate prefixes and
// per-bit half-sums into the sum and its flags. Purely combinational.
module adder_sum_cell
    import adder_sum_pipe_pkg::*;
(
    input  logic [LEN_DATA-1:0] g_prefix,
    input  logic [LEN_DATA-1:0] p_prefix,
    input  logic [LEN_DATA-1:0] p_half,
    input  logic                carry_in,
    output logic [LEN_DATA-1:0] sum,
    output logic                carry_out,
    output logic                overflow,
    output logic                zero
);

    logic [LEN_DATA-1:0] carry;

    // Carry into bit i is G[i-1:0] | P[i-1:0]&cin; bit 0 takes cin directly.
    always_comb begin
        carry     = {g_prefix[LEN_DATA-2:0] | (p_prefix[LEN_DATA-2:0] & {(LEN_DATA-1){carry_in}}),
                     carry_in};
        carry_out = g_prefix[LEN_DATA-1] | (p_prefix[LEN_DATA-1] & carry_in);
        sum       = p_half ^ carry;
        overflow  = carry[LEN_DATA-1] ^ carry_out;
        zero      = (sum == '0);
    end

endmodule

// File: rtl/adder_sum_pipe.sv
// Adder sum stage with a 2-entry in-order output buffer. Results are computed
// from the accepted prefix inputs and presented one cycle later; in_ready
// depends only on the registered occupancy, never on out_ready.
module adder_sum_pipe
    import adder_sum_pipe_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LEN_DATA-1:0] g_prefix,
    input  logic [LEN_DATA-1:0] p_prefix,
    input  logic [LEN_DATA-1:0] p_half,
    input  logic                carry_in,
    input  logic [LEN_TAG-1:0]  tag_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LEN_DATA-1:0] sum,
    output logic                carry_out,
    output logic                overflow,
    output logic                zero,
    output logic [LEN_TAG-1:0]  tag_out
);

    occ_e    state_q, state_d;
    logic    wr_ptr_q, wr_ptr_d;
    logic    rd_ptr_q, rd_ptr_d;
    result_t mem_q [2];
    result_t mem_d [2];
    result_t cell_res;
    result_t head;
    logic    push;
    logic    pop;

    adder_sum_cell u_cell (
        .g_prefix  (g_prefix),
        .p_prefix  (p_prefix),
        .p_half    (p_half),
        .carry_in  (carry_in),
        .sum       (cell_res.sum),
        .carry_out (cell_res.carry_out),
        .overflow  (cell_res.overflow),
        .zero      (cell_res.zero)
    );

    assign cell_res.tag = tag_in;

    // Handshakes and outputs: everything visible downstream comes from registers.
    always_comb begin
        in_ready  = (state_q != FULL);
        out_valid = (state_q != EMPTY);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        head      = mem_q[rd_ptr_q];
        sum       = head.sum;
        carry_out = head.carry_out;
        overflow  = head.overflow;
        zero      = head.zero;
        tag_out   = head.tag;
    end

    // Next occupancy, pointers and storage.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = cell_res;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (!push && pop) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // State register with synchronous reset; a reset edge drops any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: nonblocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q  <= EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            // NOTE: storage is only two entries, so it is cleared on reset; outputs read 0 and no stale tag returns.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_adder_sum_pipe.sv
// Directed and streaming checks for adder_sum_pipe.
module tb_adder_sum_pipe;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  g_prefix;
    logic [W-1:0]  p_prefix;
    logic [W-1:0]  p_half;
    logic          carry_in;
    logic [3:0]    tag_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          carry_out;
    logic          overflow;
    logic          zero;
    logic [3:0]    tag_out;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
        logic         z;
        logic [3:0]   tag;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t cur_exp;
    exp_t q[$];

    adder_sum_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g_prefix  (g_prefix),
        .p_prefix  (p_prefix),
        .p_half    (p_half),
        .carry_in  (carry_in),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .tag_out   (tag_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference sum and flags straight from the operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [3:0] tag, output exp_t e);
        logic [W:0] full;
        full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.sum = full[W-1:0];
        e.co  = full[W];
        e.ov  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
        e.z   = (e.sum == '0);
        e.tag = tag;
    endtask

    // Drive prefix inputs derived bit-serially from operands a, b.
    task automatic set_in(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [3:0] tag);
        logic gg, pp;
        gg = 1'b0;
        pp = 1'b1;
        for (int i = 0; i < W; i++) begin
            gg          = (a[i] & b[i]) | ((a[i] ^ b[i]) & gg);
            pp          = (a[i] ^ b[i]) & pp;
            g_prefix[i] = gg;
            p_prefix[i] = pp;
        end
        p_half   = a ^ b;
        carry_in = cin;
        tag_in   = tag;
        model(a, b, cin, tag, cur_exp);
    endtask

    // One transfer with out_ready=1: result must appear one cycle later, then drain.
    task automatic send_vec(input string name, input logic [W-1:0] g, input logic [W-1:0] p,
                            input logic [W-1:0] h, input logic cin, input logic [3:0] tag,
                            input logic [W-1:0] e_sum, input logic e_co, input logic e_ov,
                            input logic e_z);
        @(posedge clk); #1;
        g_prefix  = g;
        p_prefix  = p;
        p_half    = h;
        carry_in  = cin;
        tag_in    = tag;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({name, "_valid"}, out_valid, 1);
        check({name, "_sum"}, sum, e_sum);
        check({name, "_cout"}, carry_out, e_co);
        check({name, "_ovf"}, overflow, e_ov);
        check({name, "_zero"}, zero, e_z);
        check({name, "_tag"}, tag_out, tag);
        @(posedge clk); #1;
        check({name, "_drained"}, out_valid, 0);
    endtask

    task automatic send_ops(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic [3:0] tag,
                            input logic [W-1:0] e_sum, input logic e_co, input logic e_ov,
                            input logic e_z);
        set_in(a, b, cin, tag);
        send_vec(name, g_prefix, p_prefix, p_half, cin, tag, e_sum, e_co, e_ov, e_z);
    endtask

    initial begin
        int   n_pushed;
        int   n_popped;
        int   stag;
        logic do_push;
        logic do_pop;
        exp_t e;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        g_prefix  = '0;
        p_prefix  = '0;
        p_half    = '0;
        carry_in  = 1'b0;
        tag_in    = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_sum", sum, 0);
        check("rst_flags", {carry_out, overflow, zero}, 0);
        check("rst_tag", tag_out, 0);

        // Directed vectors with hand-computed results.
        send_vec("allprop", 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd3,
                 32'h0, 1'b1, 1'b0, 1'b1);
        send_ops("max_pos_plus1", 32'h7FFF_FFFF, 32'h1, 1'b0, 4'd5,
                 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        send_ops("wrap_zero", 32'hFFFF_FFFF, 32'h1, 1'b0, 4'd6,
                 32'h0, 1'b1, 1'b0, 1'b1);
        send_ops("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 4'd9,
                 32'h0, 1'b1, 1'b1, 1'b1);
        send_ops("mixed", 32'h1234_5678, 32'h1111_1111, 1'b1, 4'd10,
                 32'h2345_678A, 1'b0, 1'b0, 1'b0);
        send_ops("cin_only", 32'h0, 32'h0, 1'b1, 4'd15,
                 32'h1, 1'b0, 1'b0, 1'b0);

        // Backpressure: three back-to-back inputs with out_ready low.
        @(posedge clk); #1;
        out_ready = 1'b0;
        set_in(32'd10, 32'd1, 1'b0, 4'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("bp_ready_one", in_ready, 1);
        check("bp_tag_one", tag_out, 1);
        set_in(32'd20, 32'd2, 1'b0, 4'd2);
        @(posedge clk); #1;
        check("bp_ready_full", in_ready, 0);
        set_in(32'd30, 32'd3, 1'b0, 4'd3);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold_ready", in_ready, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_tag", tag_out, 1);
            check("bp_hold_sum", sum, 11);
            check("bp_hold_flags", {carry_out, overflow, zero}, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_rel_tag2", tag_out, 2);
        check("bp_rel_sum2", sum, 22);
        check("bp_rel_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_rel_tag3", tag_out, 3);
        check("bp_rel_sum3", sum, 33);
        check("bp_rel_valid3", out_valid, 1);
        @(posedge clk); #1;
        check("bp_rel_empty", out_valid, 0);
        check("bp_rel_ready_end", in_ready, 1);

        // Streaming with random out_ready against a scoreboard.
        n_pushed = 0;
        n_popped = 0;
        stag     = 0;
        @(posedge clk); #1;
        set_in($urandom, $urandom, 1'($urandom_range(0, 1)), 4'(stag));
        in_valid  = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            do_push = in_valid && in_ready;
            do_pop  = out_valid && out_ready;
            if (do_pop) begin
                if (q.size() == 0) begin
                    check("stream_unexpected_pop", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("stream_tag", tag_out, e.tag);
                    check("stream_sum", sum, e.sum);
                    check("stream_flags", {carry_out, overflow, zero}, {e.co, e.ov, e.z});
                end
                n_popped++;
            end
            if (do_push) begin
                q.push_back(cur_exp);
                n_pushed++;
            end
            @(posedge clk); #1;
            if (do_push) begin
                stag++;
                set_in($urandom, $urandom, 1'($urandom_range(0, 1)), 4'(stag));
            end
            out_ready = 1'($urandom_range(0, 1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("drain_unexpected_pop", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("drain_tag", tag_out, e.tag);
                    check("drain_sum", sum, e.sum);
                end
                n_popped++;
            end
            @(posedge clk); #1;
        end
        check("stream_count", 64'(n_popped), 64'(n_pushed));
        check("stream_left", 64'(q.size()), 0);
        check("stream_progress", 64'(n_pushed > 100), 1);

        // Reset while FULL discards both entries and the offered input.
        @(posedge clk); #1;
        out_ready = 1'b0;
        set_in(32'd1, 32'd1, 1'b0, 4'd7);
        in_valid = 1'b1;
        @(posedge clk); #1;
        set_in(32'd2, 32'd2, 1'b0, 4'd8);
        @(posedge clk); #1;
        check("rst_full_ready", in_ready, 0);
        set_in(32'd3, 32'd3, 1'b0, 4'd9);
        out_ready = 1'b1;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_tag", tag_out, 0);
        check("midrst_sum", sum, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midrst_quiet", {out_valid, tag_out}, 0);
        end
        send_ops("post_rst", 32'd5, 32'd6, 1'b0, 4'd4, 32'd11, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
